// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the weighted round-robin arbiter with packet
//   lock (arb_wrr_lock) and its rotating-priority picker (arb_rr_pick).
//   Contents:
//     arb_state_e   IDLE (no owner) / OWN (one requester holds the grant)
//     idx_w()       index width for a given requester count (min 1 bit)
//     weight_field() extracts weight field idx from a packed weight vector
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Upper bounds accepted by weight_field(); callers cast their packed
  // weight vector up to MAX_CFG_W and the result down to their field width.
  localparam int MAX_CFG_W = 256;
  localparam int MAX_WW    = 8;

  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic logic [MAX_WW-1:0] weight_field(
    input logic [MAX_CFG_W-1:0] cfg,
    input int                   idx,
    input int                   ww
  );
    logic [MAX_WW-1:0] f;
    f = '0;
    for (int b = 0; b < MAX_WW; b++) begin
      if (b < ww) f[b] = cfg[idx * ww + b];
    end
    return f;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
//   Combinational rotating-priority picker. The search starts at
//   i_last_owner+1 (mod WIDTH), so i_last_owner has the lowest priority and
//   can only win when it is the sole requester.
//   Method: duplicate the request vector, take the WIDTH-bit window starting
//   at the search origin, find the first set bit, then add the origin back
//   to recover the absolute index.
// Ports:
//   i_req        in  WIDTH  request vector
//   i_last_owner in  IDX_W  index that had the grant most recently
//   o_pick       out WIDTH  one-hot winner (zero when no request)
//   o_pick_idx   out IDX_W  index of the winner
//   o_any        out 1      at least one request present
// -----------------------------------------------------------------------------
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_owner,
  output logic [WIDTH-1:0] o_pick,
  output logic [IDX_W-1:0] o_pick_idx,
  output logic             o_any
);

  logic [2*WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0]   w_rot;
  logic               w_found;
  int                 w_start;
  int                 w_off;

  // NOTE: every variable assigned in always_comb gets a default at the top of
  // the block, so no path can leave it holding its old value (no latch).
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_start = (int'(i_last_owner) + 1) % WIDTH;
    w_rot   = '0;
    w_found = 1'b0;
    w_off   = 0;
    for (int k = 0; k < WIDTH; k++) begin
      w_rot[k] = w_dbl[w_start + k];
    end
    for (int k = 0; k < WIDTH; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = k;
      end
    end
    o_any      = w_found;
    o_pick_idx = IDX_W'((w_start + w_off) % WIDTH);
    o_pick     = w_found ? (WIDTH'(1) << o_pick_idx) : '0;
  end

endmodule

// File: rtl/arb_wrr_lock.sv
// -----------------------------------------------------------------------------
// arb_wrr_lock
//   Weighted round-robin arbiter with packet lock. The owner keeps the grant
//   for whole packets, up to its latched weight in packets per turn; a turn
//   also ends when the owner has no valid beat between packets. On end of turn
//   the next owner is picked in the same cycle, so handoff has no idle cycle.
// Ports:
//   clk        in  1         clock, rising edge
//   rst_n      in  1         asynchronous active-low reset
//   v_vld      in  WIDTH     per-requester beat valid
//   v_last     in  WIDTH     per-requester last beat of packet
//   cfg_weight in  WIDTH*WW  packets per turn, field i at [i*WW +: WW], 0 -> 1
//   v_grant    out WIDTH     registered one-hot grant, zero when idle
//   grant_idx  out IDX_W     index of current owner (valid when busy)
//   busy       out 1         owner present
// -----------------------------------------------------------------------------
module arb_wrr_lock
  import arb_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int WW    = 3,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    v_vld,
  input  logic [WIDTH-1:0]    v_last,
  input  logic [WIDTH*WW-1:0] cfg_weight,
  output logic [WIDTH-1:0]    v_grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                busy
);

  arb_state_e       r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_grant,      w_grant_nxt;
  logic [IDX_W-1:0] r_idx,        w_idx_nxt;
  logic [IDX_W-1:0] r_last_owner, w_last_owner_nxt;
  logic [WW-1:0]    r_w,          w_w_nxt;
  logic [WW-1:0]    r_pkt_cnt,    w_pkt_cnt_nxt;
  logic             r_in_pkt,     w_in_pkt_nxt;
  logic             r_busy,       w_busy_nxt;

  logic [WIDTH-1:0] w_pick;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_any;
  logic [WW-1:0]    w_field;
  logic [WW-1:0]    w_pick_w;
  logic             w_own_vld;
  logic             w_own_last;
  logic             w_beat;
  logic             w_turn_end;

  arb_rr_pick #(.WIDTH(WIDTH)) u_pick (
    .i_req        (v_vld),
    .i_last_owner (r_last_owner),
    .o_pick       (w_pick),
    .o_pick_idx   (w_pick_idx),
    .o_any        (w_any)
  );

  // Weight of the candidate winner; 0 is promoted to 1 so every turn carries
  // at least one packet. Latched on grant so mid-turn changes are ignored.
  assign w_field  = WW'(weight_field(MAX_CFG_W'(cfg_weight), int'(w_pick_idx), WW));
  assign w_pick_w = (w_field == '0) ? WW'(1) : w_field;

  assign w_own_vld  = v_vld[r_idx];
  assign w_own_last = v_last[r_idx];
  assign w_beat     = (r_state == OWN) && w_own_vld;
  // pkt_cnt stops at w-1: the last packet of the turn ends the turn instead
  // of incrementing, so the counter never wraps.
  assign w_turn_end = (w_beat && w_own_last && (r_pkt_cnt == r_w - WW'(1))) ||
                      (!r_in_pkt && !w_own_vld);

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_idx_nxt        = r_idx;
    w_last_owner_nxt = r_last_owner;
    w_w_nxt          = r_w;
    w_pkt_cnt_nxt    = r_pkt_cnt;
    w_in_pkt_nxt     = r_in_pkt;
    w_busy_nxt       = r_busy;

    // A new grant is taken from IDLE, or at end of turn when someone asks.
    // Both cases share the same latch-on-grant behaviour.
    if ((r_state == IDLE || w_turn_end) && w_any) begin
      w_state_nxt      = OWN;
      w_grant_nxt      = w_pick;
      w_idx_nxt        = w_pick_idx;
      w_last_owner_nxt = w_pick_idx;
      w_w_nxt          = w_pick_w;
      w_pkt_cnt_nxt    = '0;
      w_in_pkt_nxt     = 1'b0;
      w_busy_nxt       = 1'b1;
    end else if (r_state == OWN && w_turn_end) begin
      w_state_nxt  = IDLE;
      w_grant_nxt  = '0;
      w_busy_nxt   = 1'b0;
      w_in_pkt_nxt = 1'b0;
    end else if (w_beat) begin
      if (w_own_last) begin
        w_in_pkt_nxt  = 1'b0;
        w_pkt_cnt_nxt = r_pkt_cnt + WW'(1);
      end else begin
        w_in_pkt_nxt  = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_idx        <= '0;
      r_last_owner <= IDX_W'(WIDTH - 1);
      r_w          <= WW'(1);
      r_pkt_cnt    <= '0;
      r_in_pkt     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_idx        <= w_idx_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_w          <= w_w_nxt;
      r_pkt_cnt    <= w_pkt_cnt_nxt;
      r_in_pkt     <= w_in_pkt_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign v_grant   = r_grant;
  assign grant_idx = r_idx;
  assign busy      = r_busy;

endmodule
